// File: rtl/ifu_pc_pkg.sv
// Shared definitions for the fetch unit: next-PC source encodings, reset PC, NOP and the IF/ID record.
package ifu_pc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // Word offset of a branch, sign-extended and scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_npc.sv
// Next-PC select: purely combinational; redirect targets are relative to the decode-stage pc+4.
module npc
  import ifu_pc_pkg::*;
(
  input  logic [31:0] ifid_pc4,
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] ra,
  output logic [31:0] next_pc,
  output logic        taken
);

  npc_sel_e    sel;
  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        unused_ra_low;

  assign sel           = npc_sel_e'(npc_sel);
  assign seq_pc        = pc + 32'd4;
  // JR targets are forced word-aligned; the dropped bits carry no meaning here.
  assign unused_ra_low = ^ra[1:0];

  always_comb begin
    target = seq_pc;
    taken  = 1'b0;
    unique case (sel)
      NPC_SEQ: begin
        target = seq_pc;
        taken  = 1'b0;
      end
      NPC_BRANCH: begin
        target = ifid_pc4 + branch_offset(imm16);
        taken  = zero;
      end
      NPC_JUMP: begin
        target = {ifid_pc4[31:28], target26, 2'b00};
        taken  = 1'b1;
      end
      NPC_JR: begin
        target = {ra[31:2], 2'b00};
        taken  = 1'b1;
      end
    endcase
  end

  assign next_pc = taken ? target : seq_pc;

endmodule

// File: rtl/ifu_pc.sv
// Fetch unit: PC register plus IF/ID register; one-cycle fetch latency, one bubble per taken redirect.
// Stall freezes PC and IF/ID and ignores any redirect; reset overrides everything at the same edge.
module ifu_pc
  import ifu_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] ra,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [9:0]  im_addr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  logic [31:0] pc_q;
  ifid_t       ifid_q;
  logic [31:0] next_pc;
  logic        taken;

  npc u_npc (
    .ifid_pc4 (ifid_q.pc4),
    .pc       (pc_q),
    .npc_sel  (npc_sel),
    .zero     (zero),
    .imm16    (imm16),
    .target26 (target26),
    .ra       (ra),
    .next_pc  (next_pc),
    .taken    (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= '{instr: NOP, pc4: 32'd0, valid: 1'b0};
    end else if (!stall) begin
      pc_q       <= next_pc;
      ifid_q.pc4 <= pc_q + 32'd4;
      // The word fetched alongside a taken redirect is on the wrong path.
      if (taken) begin
        ifid_q.instr <= NOP;
        ifid_q.valid <= 1'b0;
      end else begin
        ifid_q.instr <= instr_in;
        ifid_q.valid <= 1'b1;
      end
    end
  end

  assign pc         = pc_q;
  assign im_addr    = pc_q[11:2];
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_ifu_pc.sv
// Bench for ifu_pc: directed vector table, then random control against a reference model.
module tb_ifu_pc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        zero = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic [31:0] ra = '0;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [9:0]  im_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  logic [31:0] imem [1024];
  logic        use_rand = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Instruction memory: a recognisable pattern for the table, random contents afterwards.
  assign instr_in = use_rand ? imem[im_addr] : {16'hC0DE, 6'h00, im_addr};

  ifu_pc dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .zero       (zero),
    .imm16      (imm16),
    .target26   (target26),
    .ra         (ra),
    .instr_in   (instr_in),
    .pc         (pc),
    .im_addr    (im_addr),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic        zero;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] ra;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid);
    logic [9:0] e_addr;
    e_addr = e_pc[11:2];
    check({tag, " pc"}, pc, e_pc);
    check({tag, " im_addr"}, {22'd0, im_addr}, {22'd0, e_addr});
    check({tag, " ifid_instr"}, ifid_instr, e_instr);
    check({tag, " ifid_pc4"}, ifid_pc4, e_pc4);
    check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
  endtask

  // Reference model state: what decode should see, from the architectural rules.
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;

  task automatic model_step(input logic r, input logic s, input logic [1:0] sel, input logic z,
                            input logic [15:0] imm, input logic [25:0] t26, input logic [31:0] rv);
    logic signed [31:0] off;
    logic [31:0] tgt;
    logic        tk;
    if (r) begin
      m_pc = 32'h3000; m_pc4 = 0; m_instr = 0; m_valid = 0;
    end else if (!s) begin
      off = 32'($signed(imm));
      tk  = 1'b0;
      tgt = 0;
      if (sel == 2'd1 && z) begin tk = 1; tgt = m_pc4 + 32'(off * 4); end
      if (sel == 2'd2) begin tk = 1; tgt = (m_pc4 & 32'hF000_0000) | (32'(t26) * 4); end
      if (sel == 2'd3) begin tk = 1; tgt = rv & ~32'd3; end
      m_instr = tk ? 32'd0 : imem[m_pc[11:2]];
      m_valid = !tk;
      m_pc4   = m_pc + 4;
      m_pc    = tk ? tgt : m_pc + 4;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;

    //            rst stall sel   z  imm       tgt26        ra            pc            instr         pc4           v
    tbl.push_back('{1, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_3000, 32'h0,         32'h0,         0});
    tbl.push_back('{1, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_3000, 32'h0,         32'h0,         0});
    tbl.push_back('{0, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_3004, 32'hC0DE_0000, 32'h0000_3004, 1});
    tbl.push_back('{0, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_3008, 32'hC0DE_0001, 32'h0000_3008, 1});
    tbl.push_back('{0, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_300C, 32'hC0DE_0002, 32'h0000_300C, 1});
    tbl.push_back('{0, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_3010, 32'hC0DE_0003, 32'h0000_3010, 1});
    tbl.push_back('{0, 0, 2'd1, 1, 16'hFFFF, 26'h0, 32'h0,          32'h0000_300C, 32'h0,         32'h0000_3014, 0});
    tbl.push_back('{0, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_3010, 32'hC0DE_0003, 32'h0000_3010, 1});
    tbl.push_back('{0, 0, 2'd1, 0, 16'hFFFF, 26'h0, 32'h0,          32'h0000_3014, 32'hC0DE_0004, 32'h0000_3014, 1});
    tbl.push_back('{0, 0, 2'd2, 0, 16'h0000, 26'hC20, 32'h0,        32'h0000_3080, 32'h0,         32'h0000_3018, 0});
    tbl.push_back('{0, 0, 2'd3, 0, 16'h0000, 26'h0, 32'h0000_3013,  32'h0000_3010, 32'h0,         32'h0000_3084, 0});
    tbl.push_back('{0, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_3014, 32'hC0DE_0004, 32'h0000_3014, 1});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{0, 1, 2'd2, 0, 16'h0000, 26'hC20, 32'h0,      32'h0000_3014, 32'hC0DE_0004, 32'h0000_3014, 1});
    tbl.push_back('{0, 0, 2'd2, 0, 16'h0000, 26'hC20, 32'h0,        32'h0000_3080, 32'h0,         32'h0000_3018, 0});
    tbl.push_back('{0, 0, 2'd3, 0, 16'h0000, 26'h0, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,         32'h0000_3084, 0});
    tbl.push_back('{0, 0, 2'd0, 0, 16'h0000, 26'h0, 32'h0,          32'h0000_0000, 32'hC0DE_03FF, 32'h0000_0000, 1});
    tbl.push_back('{0, 0, 2'd1, 1, 16'hFFFF, 26'h0, 32'h0,          32'hFFFF_FFFC, 32'h0,         32'h0000_0004, 0});
    tbl.push_back('{1, 1, 2'd2, 0, 16'h0000, 26'hC20, 32'h0,        32'h0000_3000, 32'h0,         32'h0,         0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; stall = tbl[i].stall; npc_sel = tbl[i].sel; zero = tbl[i].zero;
      imm16 = tbl[i].imm; target26 = tbl[i].tgt; ra = tbl[i].ra;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_valid);
    end

    // Random control traffic; the first cycle resets so the model starts aligned.
    @(negedge clk);
    use_rand = 1'b1;
    m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst      = (c == 0) || ($urandom_range(0, 39) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      npc_sel  = 2'($urandom_range(0, 3));
      zero     = 1'($urandom);
      imm16    = 16'($urandom);
      target26 = 26'($urandom);
      ra       = (($urandom_range(0, 1) == 0) ? 32'h0000_3000 : 32'h0) | ($urandom & 32'hFFF) |
                 (($urandom_range(0, 3) == 0) ? $urandom : 32'h0);
      model_step(rst, stall, npc_sel, zero, imm16, target26, ra);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", c), m_pc, m_instr, m_pc4, m_valid);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_pc.md
# ifu_pc

Instruction-fetch unit for the MIPS pipeline. Holds the program counter, drives the 10-bit word address into the 4 KB instruction memory, selects the next PC (sequential, conditional branch, jump, jump-register) and captures the fetched instruction into the IF/ID pipeline register. It sits directly upstream of the instruction memory and directly upstream of the decode/control stage.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- npc_sel  in  2  next-PC source from decode: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JR.
- zero  in  1  branch condition from decode; used only when npc_sel = BRANCH.
- imm16  in  16  branch offset in words, signed.
- target26  in  26  jump target field.
- ra  in  32  register value for JR.
- instr_in  in  32  instruction word returned by instruction memory, combinational on im_addr.
- pc  out  32  current fetch PC.
- im_addr  out  10  pc[11:2], to instruction memory.
- ifid_instr  out  32  instruction latched for decode.
- ifid_pc4  out  32  fetch PC + 4 of the latched instruction.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Redirect is resolved in decode, relative to ifid_pc4:
  - BRANCH target = ifid_pc4 + (sign_extend(imm16) << 2); taken only when zero = 1, otherwise the cycle behaves as SEQ.
  - JUMP target = {ifid_pc4[31:28], target26, 2'b00}.
  - JR target = {ra[31:2], 2'b00}; the two low bits of ra are silently dropped.
- Redirect taken = (npc_sel = BRANCH and zero) or npc_sel = JUMP or npc_sel = JR.
- No delay slot. On a taken redirect the instruction fetched in that cycle is discarded:
  - IF/ID loads ifid_instr = 32'h0000_0000 (NOP) and ifid_valid = 0.
  - ifid_pc4 is still loaded with pc + 4.
- Otherwise, when not stalled: IF/ID loads instr_in, pc + 4 and valid = 1.
- Priority at each rising edge: rst > stall > taken redirect > sequential.
  - rst: pc = RESET_PC; ifid_instr = 0; ifid_pc4 = 0; ifid_valid = 0.
  - stall: pc and all IF/ID outputs hold. A redirect presented during stall is ignored; decode must hold npc_sel and its operands until stall drops.
  - redirect: pc = target.
  - sequential: pc = pc + 4.
- Arithmetic is 32-bit modulo 2^32. pc + 4 at 32'hFFFF_FFFC wraps to 0. Branch targets wrap the same way.
- im_addr always equals pc[11:2]. PCs outside 0x3000–0x3FFF alias into the 4 KB memory; no error is flagged.

## Timing
- All state updates on the rising edge of clk. Outputs are registered except im_addr, which is a direct slice of the pc register.
- Fetch latency: im_addr is valid in cycle N and instr_in is sampled at the end of cycle N; the instruction appears on ifid_instr in cycle N+1.
- Redirect latency: taken redirect sampled at edge N; pc = target in cycle N+1; the target instruction appears on ifid_instr in cycle N+2. Exactly one bubble is inserted.
- Reset mid-operation, including during stall or with a redirect pending, takes effect at the same edge and discards everything in flight.

## Structure
- Shared package: NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_JR encodings, default RESET_PC, NOP constant 32'h0.
- One combinational sub-module, `npc`: takes ifid_pc4, pc, npc_sel, zero, imm16, target26 and ra; produces next_pc and a taken flag.
- Top level holds the pc register, the IF/ID register and the priority logic.

## Test plan
- Reset: assert rst for 2 cycles, then release -> pc = 32'h3000, im_addr = 10'h000, ifid_valid = 0; after 3 further edges pc = 32'h300C and ifid_pc4 = 32'h300C.
- Taken branch: ifid_pc4 = 32'h3010, npc_sel = 01, zero = 1, imm16 = 16'hFFFF -> next pc = 32'h300C; following IF/ID is NOP with valid = 0.
- Not-taken branch: same stimulus with zero = 0 -> pc advances by 4; ifid_valid stays 1.
- JUMP and JR:
  - JUMP with target26 = 26'h0000C20, ifid_pc4 = 32'h3008 -> pc = 32'h0000_3080.
  - JR with ra = 32'h0000_3013 -> pc = 32'h0000_3010.
- Stall with pending redirect: stall = 1 for 3 cycles while npc_sel = JUMP -> pc and IF/ID unchanged throughout; the jump takes effect on the first edge after stall drops.
- Wrap and reset during stall:
  - Force pc = 32'hFFFF_FFFC with a JR, then run sequential -> pc = 0.
  - Assert rst while stall = 1 -> pc = 32'h3000 on that edge.
